exec_sequencer: RTL and testbench

Sequences one calculator instruction (SRC, DST, ALU_OP) through the register memory and the shared ALU. It sits between the keypad command parser and the datapath.
- On the parser's finish strobe it latches the instruction.
- It then reads operand A from SRC and operand B from DST, and runs the ALU.
- It writes the result back to DST and updates the ANS register.
- The special address IC_ANS selects the internal ANS register instead of memory.

---
 rtl/exec_sequencer_pkg.sv | 30 +++
 rtl/exec_sequencer_if.sv | 24 ++
 rtl/exec_sequencer_mem_port.sv | 58 +++++
 rtl/exec_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared constants for the calculator instruction sequencer: opcode and
// address widths, the IC_ANS pseudo-address, ALU opcodes and FSM states.
package exec_sequencer_pkg;

  localparam int IC_N  = 4;
  localparam int IC_AW = 16;

  localparam logic [IC_AW-1:0] IC_ANS = 16'hFFFF;

  localparam logic [IC_N-1:0] IC_OPAD = 4'd0;
  localparam logic [IC_N-1:0] IC_OPSB = 4'd1;
  localparam logic [IC_N-1:0] IC_OPAN = 4'd2;
  localparam logic [IC_N-1:0] IC_OPOR = 4'd3;
  localparam logic [IC_N-1:0] IC_OPXR = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Range check on the full-width address, done before any truncation.
  function automatic logic addr_in_range(input logic [IC_AW-1:0] a, input int aw);
    return (a >> aw) == '0;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Register-memory bus between the sequencer (master) and the memory (slave).
interface exec_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/exec_sequencer_mem_port.sv
// Memory request port: holds rd/wr until ack and, with EXEC_SEQ_MEM_TIMEOUT_EN
// defined, aborts a request that sees no ack within TIMEOUT cycles.
module exec_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_timeout,
  exec_sequencer_if.master  mem
);

  logic w_req;
  logic w_wr;

  assign w_req = i_rd_req | i_wr_req;
  assign w_wr  = i_wr_req & ~i_rd_req;

  assign mem.mem_rd    = i_rd_req;
  assign mem.mem_wr    = w_wr;
  assign mem.mem_addr  = w_req ? i_addr : '0;
  assign mem.mem_wdata = w_wr ? i_wdata : '0;

  assign o_ack   = w_req & mem.mem_ack;
  assign o_rdata = mem.mem_rdata;

`ifdef EXEC_SEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CNT_W-1:0] r_wait_cnt;

  // Reloads whenever no request is pending or one completes, so every
  // request-holding state starts with a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= CNT_W'(TIMEOUT - 1);
    end else if (!w_req || mem.mem_ack) begin
      r_wait_cnt <= CNT_W'(TIMEOUT - 1);
    end else if (r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  assign o_timeout = w_req & ~mem.mem_ack & (r_wait_cnt == '0);
`else
  logic w_unused;
  assign w_unused  = ^{clk, rst_n, TIMEOUT[0]};
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/exec_sequencer.sv
// Executes one calculator instruction: read A, read B, ALU, write back, retire.
// Optional macro EXEC_SEQ_MEM_TIMEOUT_EN enables the memory-ack timeout.
//   state  | meaning
//   IDLE   | waiting for finish
//   RD_A   | fetch operand A from SRC (or ANS)
//   RD_B   | fetch operand B from DST (or ANS)
//   EXEC   | ALU result captured into R
//   WR     | ANS <= R, write R to DST unless DST is ANS
//   DONE   | one-cycle retire pulse
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IC_AW-1:0]  i_src,
  input  logic [IC_AW-1:0]  i_dst,
  input  logic [IC_N-1:0]   i_alu_op,
  input  logic              i_finish,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_ans,
  output logic [IC_N-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_y,
  exec_sequencer_if.master  mem
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IC_AW-1:0]  r_src;
  logic [IC_AW-1:0]  r_dst;
  logic [IC_N-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_r;
  logic [DATA_W-1:0] r_ans;
  logic              r_err;

  logic              w_latch;
  logic              w_ld_opnd;
  logic              w_ld_r;
  logic              w_ld_ans;
  logic              w_err_set;
  logic              w_rd_req;
  logic              w_wr_req;
  logic [ADDR_W-1:0] w_port_addr;
  logic [DATA_W-1:0] w_ld_val;
  logic [IC_AW-1:0]  w_op_addr;
  state_t            w_after_rd;
  logic              w_ack;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rdata;

  assign w_op_addr  = (r_state == S_RD_B) ? r_dst : r_src;
  assign w_after_rd = (r_state == S_RD_A) ? S_RD_B : S_EXEC;

  exec_mem_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_mem_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_req  (w_rd_req),
    .i_wr_req  (w_wr_req),
    .i_addr    (w_port_addr),
    .i_wdata   (r_r),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata),
    .o_timeout (w_timeout),
    .mem       (mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ld_opnd   = 1'b0;
    w_ld_r      = 1'b0;
    w_ld_ans    = 1'b0;
    w_err_set   = 1'b0;
    w_rd_req    = 1'b0;
    w_wr_req    = 1'b0;
    w_port_addr = '0;
    w_ld_val    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_finish) begin
          w_latch     = 1'b1;
          w_state_nxt = S_RD_A;
        end
      end
      S_RD_A, S_RD_B: begin
        if (w_op_addr == IC_ANS) begin
          w_ld_val    = r_ans;
          w_ld_opnd   = 1'b1;
          w_state_nxt = w_after_rd;
        end else if (!addr_in_range(w_op_addr, ADDR_W)) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_rd_req    = 1'b1;
          w_port_addr = ADDR_W'(w_op_addr);
          w_ld_val    = w_rdata;
          if (w_ack) begin
            w_ld_opnd   = 1'b1;
            w_state_nxt = w_after_rd;
          end else if (w_timeout) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_EXEC: begin
        w_ld_r      = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (r_dst == IC_ANS) begin
          w_ld_ans    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_wr_req    = 1'b1;
          w_port_addr = ADDR_W'(r_dst);
          if (w_ack) begin
            w_ld_ans    = 1'b1;
            w_state_nxt = S_DONE;
          end else if (w_timeout) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // A new finish while an instruction is in flight is an overrun.
    if (i_finish && (r_state != S_IDLE)) begin
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_r   <= '0;
      r_ans <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_src <= i_src;
        r_dst <= i_dst;
        r_op  <= i_alu_op;
      end
      if (w_ld_opnd) begin
        if (r_state == S_RD_A) begin
          r_a <= w_ld_val;
        end else begin
          r_b <= w_ld_val;
        end
      end
      if (w_ld_r) begin
        r_r <= i_alu_y;
      end
      if (w_ld_ans) begin
        r_ans <= r_r;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_latch) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_err    = r_err;
  assign o_ans    = r_ans;
  assign o_alu_op = r_op;
  assign o_alu_a  = r_a;
  assign o_alu_b  = r_b;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table of instructions against a memory
// responder and ALU model, plus reset-abort and (optional) timeout sequences.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic [IC_AW-1:0]  i_src;
  logic [IC_AW-1:0]  i_dst;
  logic [IC_N-1:0]   i_alu_op;
  logic              i_finish;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [DATA_W-1:0] o_ans;
  logic [IC_N-1:0]   o_alu_op;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [DATA_W-1:0] alu_y;

  exec_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  exec_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_src    (i_src),
    .i_dst    (i_dst),
    .i_alu_op (i_alu_op),
    .i_finish (i_finish),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_ans    (o_ans),
    .o_alu_op (o_alu_op),
    .o_alu_a  (o_alu_a),
    .o_alu_b  (o_alu_b),
    .i_alu_y  (alu_y),
    .mem      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_y = '0;
    case (o_alu_op)
      IC_OPAD: alu_y = o_alu_a + o_alu_b;
      IC_OPSB: alu_y = o_alu_a - o_alu_b;
      IC_OPAN: alu_y = o_alu_a & o_alu_b;
      IC_OPOR: alu_y = o_alu_a | o_alu_b;
      IC_OPXR: alu_y = o_alu_a ^ o_alu_b;
      default: alu_y = '0;
    endcase
  end

  // Memory responder: acks after ack_dly wait cycles, logs transfers and
  // watches bus rules.
  logic [DATA_W-1:0] mem_arr [0:255];
  int                ack_dly = 0;
  bit                ack_never = 0;
  int                wcnt = 0;
  int                n_rd, n_wr, rd_hi;
  int                rd0, wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  int                stable_bad = 0;
  int                both_bad = 0;
  int                idle_addr_bad = 0;

  always @(negedge clk) begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    if (mif.mem_rd || mif.mem_wr) begin
      if (mif.mem_rd) rd_hi++;
      if (mif.mem_rd && mif.mem_wr) both_bad++;
      if (wcnt == 0) begin
        hold_addr = mif.mem_addr;
        hold_data = mif.mem_wdata;
      end else if (mif.mem_addr != hold_addr || (mif.mem_wr && mif.mem_wdata != hold_data)) begin
        stable_bad++;
      end
      if (!ack_never && wcnt == ack_dly) begin
        mif.mem_ack = 1'b1;
        wcnt = 0;
        if (mif.mem_rd) begin
          mif.mem_rdata = mem_arr[mif.mem_addr];
          if (n_rd == 0) rd0 = int'(mif.mem_addr);
          n_rd++;
        end else begin
          mem_arr[mif.mem_addr] = mif.mem_wdata;
          wa = int'(mif.mem_addr);
          wd = mif.mem_wdata;
          n_wr++;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (mif.mem_addr != '0) idle_addr_bad++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [IC_AW-1:0] s, input logic [IC_AW-1:0] d,
                     input logic [IC_N-1:0] op, input int ovr,
                     output int cyc, output logic busy_post, output logic err_post);
    n_rd  = 0;
    n_wr  = 0;
    rd_hi = 0;
    @(negedge clk);
    i_src    = s;
    i_dst    = d;
    i_alu_op = op;
    i_finish = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      i_finish = (k == ovr);
      if (o_done) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_wait: no done pulse within 200 cycles");
    end
    @(negedge clk);
    i_finish  = 1'b0;
    busy_post = o_busy;
    err_post  = o_err;
  endtask

  typedef struct {
    logic [IC_AW-1:0]  src;
    logic [IC_AW-1:0]  dst;
    logic [IC_N-1:0]   op;
    int                dly;
    int                ovr;
    logic [DATA_W-1:0] exp_ans;
    bit                exp_err;
    int                exp_cyc;
    int                exp_nrd;
    int                exp_rd0;
    int                exp_nwr;
    int                exp_wa;
    logic [DATA_W-1:0] exp_wd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int   cyc;
    logic bp, ep;

    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[3] = 16'd5;
    mem_arr[7] = 16'd9;

    //           src     dst      op       dly ovr ans  err cyc nrd rd0 nwr wa  wd
    vecs[0] = '{16'd3,   16'd7,   IC_OPAD, 0,  0,  14,  0,  5,  2,  3,  1,  7,  14};
    vecs[1] = '{IC_ANS,  IC_ANS,  IC_OPSB, 0,  0,  0,   0,  5,  0,  0,  0,  0,  0};
    vecs[2] = '{16'd3,   16'd7,   IC_OPAD, 3,  0,  19,  0,  14, 2,  3,  1,  7,  19};
    vecs[3] = '{16'd300, 16'd7,   IC_OPAD, 0,  0,  19,  1,  2,  0,  0,  0,  0,  0};
    vecs[4] = '{16'd7,   IC_ANS,  IC_OPAD, 1,  0,  38,  0,  6,  1,  7,  0,  0,  0};
    vecs[5] = '{IC_ANS,  16'd3,   IC_OPXR, 0,  0,  35,  0,  5,  1,  3,  1,  3,  35};
    vecs[6] = '{16'd3,   16'h100, IC_OPAD, 0,  0,  35,  1,  3,  1,  3,  0,  0,  0};
    vecs[7] = '{16'd3,   16'd7,   IC_OPAD, 0,  2,  54,  1,  5,  2,  3,  1,  7,  54};
    vecs[8] = '{IC_ANS,  IC_ANS,  IC_OPAD, 0,  5,  108, 1,  5,  0,  0,  0,  0,  0};
    vecs[9] = '{IC_ANS,  IC_ANS,  IC_OPOR, 0,  0,  108, 0,  5,  0,  0,  0,  0,  0};

    rst_n    = 1'b0;
    i_src    = '0;
    i_dst    = '0;
    i_alu_op = '0;
    i_finish = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_ans", o_ans, 0);
    check("rst_mem_rd", mif.mem_rd, 0);
    check("rst_mem_wr", mif.mem_wr, 0);
    check("rst_mem_addr", mif.mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", o_busy, 0);

    for (int v = 0; v < 10; v++) begin
      ack_dly = vecs[v].dly;
      run(vecs[v].src, vecs[v].dst, vecs[v].op, vecs[v].ovr, cyc, bp, ep);
      $display("vector %0d: cycles=%0d ans=%0d err=%0d", v, cyc, o_ans, ep);
      check($sformatf("v%0d_ans", v), o_ans, vecs[v].exp_ans);
      check($sformatf("v%0d_err", v), ep, vecs[v].exp_err);
      check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      check($sformatf("v%0d_nrd", v), n_rd, vecs[v].exp_nrd);
      check($sformatf("v%0d_nwr", v), n_wr, vecs[v].exp_nwr);
      check($sformatf("v%0d_busy_after", v), bp, 0);
      if (vecs[v].exp_nrd > 0) check($sformatf("v%0d_rd_addr", v), rd0, vecs[v].exp_rd0);
      if (vecs[v].exp_nwr > 0) begin
        check($sformatf("v%0d_wr_addr", v), wa, vecs[v].exp_wa);
        check($sformatf("v%0d_wr_data", v), wd, vecs[v].exp_wd);
      end
    end

    // Reset pulsed while the write-back is still waiting for its ack.
    ack_dly = 3;
    n_wr = 0;
    @(negedge clk);
    i_src    = 16'd3;
    i_dst    = 16'd7;
    i_alu_op = IC_OPAD;
    i_finish = 1'b1;
    @(negedge clk);
    i_finish = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mif.mem_wr) break;
      @(negedge clk);
    end
    check("pre_reset_in_wr", mif.mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_err", o_err, 0);
    check("abort_ans", o_ans, 0);
    check("abort_mem_rd", mif.mem_rd, 0);
    check("abort_mem_wr", mif.mem_wr, 0);
    check("abort_mem_addr", mif.mem_addr, 0);
    check("abort_mem_wdata", mif.mem_wdata, 0);
    check("abort_alu_a", o_alu_a, 0);
    check("abort_alu_b", o_alu_b, 0);
    check("abort_alu_op", o_alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_write", n_wr, 0);
    check("abort_mem7", mem_arr[7], 54);
    check("abort_idle", o_busy, 0);
    ack_dly = 0;

`ifdef EXEC_SEQ_MEM_TIMEOUT_EN
    ack_never = 1'b1;
    run(16'd3, 16'd7, IC_OPAD, 0, cyc, bp, ep);
    check("to_rd_cycles", rd_hi, TIMEOUT);
    check("to_cycles", cyc, TIMEOUT + 1);
    check("to_err", ep, 1);
    check("to_ans", o_ans, 0);
    check("to_nwr", n_wr, 0);
    ack_never = 1'b0;
`endif

    check("bus_stable", stable_bad, 0);
    check("bus_rd_wr_excl", both_bad, 0);
    check("bus_idle_addr", idle_addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
